// File: rtl/pipe_skid_register.sv
// Purpose: one pipeline stage with a main output register and a skid register behind it.
// Latency: an item accepted while empty appears on out the cycle after the accepting edge.
// Backpressure: in_ready is a flop that drops only when both registers are full, so out_ready never reaches it combinationally.
module pipe_skid_register #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]       FLUSH_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic accept;
  logic drain;

  // Handshake events; both depend only on flops and the current inputs.
  always_comb begin
    accept = in_valid & in_ready;
    drain  = out_valid & out_ready;
  end

  assign out = main_q;

  // Single state machine: every output (in_ready, out_valid, count) is
  // registered alongside the state so downstream timing sees clean flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else if (flush) begin
      // Kill everything in the stage, including any item offered this cycle.
      // The skid contents become dead; they are overwritten before reuse.
      state     <= EMPTY;
      main_q    <= FLUSH_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in;
            state     <= BUSY;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            // Pass-through: new item replaces the one leaving.
            main_q <= in;
          end else if (accept) begin
            // Downstream stalled: park the new item behind the live one.
            skid_q   <= in;
            state    <= FULL;
            in_ready <= 1'b0;
            count    <= 2'd2;
          end else if (drain) begin
            // main_q keeps the drained value so out is stable while idle.
            state     <= EMPTY;
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        FULL: begin
          if (drain) begin
            main_q   <= skid_q;
            state    <= BUSY;
            in_ready <= 1'b1;
            count    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          count     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed scenarios on a 32-bit stage and a
// randomized run on an 8-bit stage checked against a queue-based model.
module tb_pipe_skid_register;

  localparam logic [31:0] RV32 = 32'h5A5A_0000;
  localparam logic [31:0] FV32 = 32'h0000_0013;
  localparam logic [7:0]  RV8  = 8'hA5;
  localparam logic [7:0]  FV8  = 8'h13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  // 32-bit stage
  logic [31:0] in32 = '0;
  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] out32;
  logic        out_valid32;
  logic        out_ready32 = 1'b0;
  logic [1:0]  count32;

  // 8-bit stage
  logic [7:0]  in8 = '0;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  out8;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [1:0]  count8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_skid_register #(.WIDTH(32), .RESET_VALUE(RV32), .FLUSH_VALUE(FV32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in(in32), .in_valid(in_valid32), .in_ready(in_ready32),
    .out(out32), .out_valid(out_valid32), .out_ready(out_ready32),
    .count(count32)
  );

  pipe_skid_register #(.WIDTH(8), .RESET_VALUE(RV8), .FLUSH_VALUE(FV8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush),
    .in(in8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out(out8), .out_valid(out_valid8), .out_ready(out_ready8),
    .count(count8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic ov,
                       input logic [1:0] c, input logic ir);
    chk({tag, ".out"},       out32,       o);
    chk({tag, ".out_valid"}, {31'd0, out_valid32}, {31'd0, ov});
    chk({tag, ".count"},     {30'd0, count32},     {30'd0, c});
    chk({tag, ".in_ready"},  {31'd0, in_ready32},  {31'd0, ir});
  endtask

  task automatic offer32(input logic [31:0] d, input logic v, input logic r);
    in32 = d;
    in_valid32 = v;
    out_ready32 = r;
  endtask

  // Reference model for the 8-bit stage: the items held, oldest first.
  logic [7:0] mq[$];
  logic [7:0] last_out;

  initial begin
    logic acc, drn, stalled, fl;
    logic [7:0] prev_out;
    logic [7:0] exp_out;
    int delivered;
    int accepted;

    // ---------------- reset ----------------
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk32("reset", RV32, 1'b0, 2'd0, 1'b1);

    // ---------------- single item ----------------
    offer32(32'h0000_0011, 1'b1, 1'b1);
    step();
    chk32("single", 32'h0000_0011, 1'b1, 2'd1, 1'b1);
    offer32(32'h0, 1'b0, 1'b1);
    step();
    chk32("single_drain", 32'h0000_0011, 1'b0, 2'd0, 1'b1);

    // ---------------- streaming, one per cycle ----------------
    for (int i = 1; i <= 8; i++) begin
      offer32(i, 1'b1, 1'b1);
      step();
      chk32($sformatf("stream%0d", i), i, 1'b1, 2'd1, 1'b1);
    end
    offer32(32'h0, 1'b0, 1'b1);
    step();
    chk32("stream_end", 32'h8, 1'b0, 2'd0, 1'b1);

    // ---------------- stall fills skid, no loss ----------------
    offer32(32'hA, 1'b1, 1'b0);
    step();
    chk32("stall_a", 32'hA, 1'b1, 2'd1, 1'b1);
    offer32(32'hB, 1'b1, 1'b0);
    step();
    chk32("stall_full", 32'hA, 1'b1, 2'd2, 1'b0);
    offer32(32'hC, 1'b1, 1'b0);
    step();
    chk32("stall_c_held1", 32'hA, 1'b1, 2'd2, 1'b0);
    step();
    chk32("stall_c_held2", 32'hA, 1'b1, 2'd2, 1'b0);
    offer32(32'hC, 1'b1, 1'b1);
    step();
    chk32("release_b", 32'hB, 1'b1, 2'd1, 1'b1);
    step();
    chk32("release_c", 32'hC, 1'b1, 2'd1, 1'b1);
    offer32(32'h0, 1'b0, 1'b1);
    step();
    chk32("release_end", 32'hC, 1'b0, 2'd0, 1'b1);

    // ---------------- flush in FULL ----------------
    offer32(32'hA, 1'b1, 1'b0);
    step();
    offer32(32'hB, 1'b1, 1'b0);
    step();
    chk32("pre_flush_full", 32'hA, 1'b1, 2'd2, 1'b0);
    offer32(32'hD, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk32("flush_full", FV32, 1'b0, 2'd0, 1'b1);
    offer32(32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk32($sformatf("flush_quiet%0d", i), FV32, 1'b0, 2'd0, 1'b1);
    end

    // ---------------- flush in BUSY with a simultaneous accept ----------------
    offer32(32'h0000_00E1, 1'b1, 1'b0);
    step();
    offer32(32'h0000_00E2, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer32(32'h0, 1'b0, 1'b1);
    chk32("flush_accept", FV32, 1'b0, 2'd0, 1'b1);
    step();
    chk32("flush_accept_quiet", FV32, 1'b0, 2'd0, 1'b1);

    // ---------------- reset beats flush in FULL ----------------
    offer32(32'hA, 1'b1, 1'b0);
    step();
    offer32(32'hB, 1'b1, 1'b0);
    step();
    offer32(32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    chk32("reset_over_flush", RV32, 1'b0, 2'd0, 1'b1);

    // ---------------- randomized run on the 8-bit stage ----------------
    mq.delete();
    last_out  = RV8;
    delivered = 0;
    accepted  = 0;
    chk("rnd_reset_out", {24'd0, out8}, {24'd0, RV8});
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Phases: mixed traffic, then out_ready pinned high (no FULL allowed).
      in8        = 8'($urandom);
      in_valid8  = ($urandom_range(0, 3) != 0);
      out_ready8 = (cyc >= 8000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      fl         = (cyc < 8000) && ($urandom_range(0, 255) == 0);
      flush      = fl;

      acc      = in_valid8 && (mq.size() < 2);
      drn      = (mq.size() > 0) && out_ready8;
      stalled  = (mq.size() > 0) && !out_ready8;
      prev_out = out8;
      step();

      if (fl) begin
        mq.delete();
        last_out = FV8;
      end else begin
        if (drn) begin
          last_out = mq.pop_front();
          delivered++;
        end
        if (acc) begin
          mq.push_back(in8);
          accepted++;
        end
      end

      exp_out = (mq.size() > 0) ? mq[0] : last_out;
      chk("rnd_out",       {24'd0, out8},        {24'd0, exp_out});
      chk("rnd_out_valid", {31'd0, out_valid8},  {31'd0, (mq.size() > 0)});
      chk("rnd_count",     {30'd0, count8},      32'(mq.size()));
      chk("rnd_in_ready",  {31'd0, in_ready8},   {31'd0, (mq.size() < 2)});
      if (stalled && !fl)
        chk("rnd_stall_stable", {24'd0, out8}, {24'd0, prev_out});
    end
    flush = 1'b0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    // Drain what is left and confirm everything accepted came out.
    for (int i = 0; i < 3; i++) begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        delivered++;
      end
      step();
    end
    chk("rnd_drained_count", {30'd0, count8}, 32'd0);
    chk("rnd_drained_valid", {31'd0, out_valid8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_register.md
PIPE_SKID_REGISTER -- requirements
Module: pipe_skid_register

Interface
REQ-001 Parameter WIDTH, default 32: data width of the stage.
REQ-002 Parameter RESET_VALUE, default 32'h0000_0000: value driven on out after reset.
REQ-003 Parameter FLUSH_VALUE, default 32'h0000_0000: bubble value (NOP) driven on out after flush.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 flush  input  1: synchronous, active-high stage clear (branch/exception kill).
REQ-007 in  input  WIDTH: upstream data.
REQ-008 in_valid  input  1: upstream offers in this cycle.
REQ-009 in_ready  output  1: stage accepts in this cycle; driven directly from a flop.
REQ-010 out  output  WIDTH: downstream data, from the main register.
REQ-011 out_valid  output  1: out holds a live item.
REQ-012 out_ready  input  1: downstream accepts out this cycle (deassert = stall).
REQ-013 count  output  2: items held, 0..2.

Function
REQ-014 Accept event = in_valid & in_ready; drain event = out_valid & out_ready.
REQ-015 States: EMPTY (count 0), BUSY (count 1, main live), FULL (count 2, main and skid live).
REQ-016 in_ready = 1 in EMPTY and BUSY, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-017 EMPTY: accept -> main <= in, BUSY; else stay EMPTY.
REQ-018 BUSY: accept & drain -> main <= in, stay BUSY; accept & !drain -> skid <= in, FULL; !accept & drain -> EMPTY; neither -> hold.
REQ-019 FULL: drain -> main <= skid, BUSY; else hold both registers.
REQ-020 Latency in EMPTY: item accepted at edge N appears on out with out_valid = 1 after edge N.
REQ-021 While out_valid = 1 and out_ready = 0, out stays bit-for-bit stable.
REQ-022 Items leave in acceptance order; none dropped or duplicated except by flush or reset.
REQ-023 out_valid = 0 in EMPTY; out then holds the last value written (RESET_VALUE, FLUSH_VALUE or last drained item).
REQ-024 Flush, any state: next edge -> EMPTY, count 0, out_valid 0, out <= FLUSH_VALUE, skid discarded, in_ready 1.
REQ-025 Flush with accept in the same cycle: the offered item is discarded.
REQ-026 Priority: reset > flush > normal operation.
REQ-027 Throughput: with out_ready held at 1, one item per cycle indefinitely; state never reaches FULL.

Reset
REQ-028 Reset asserted at an edge -> EMPTY, count 0, out_valid 0, in_ready 1, out = RESET_VALUE, skid cleared to RESET_VALUE.
REQ-029 Reset mid-operation (BUSY or FULL) discards all held items, same values as REQ-028.
REQ-030 Without a clock edge, reset has no effect.

Verification
REQ-031 Reset, then in = 32'h0000_0011, in_valid = 1, out_ready = 1 for one cycle -> next cycle out = 32'h0000_0011, out_valid 1, count 1; following cycle with in_valid = 0 -> out_valid 0, count 0.
REQ-032 Streaming 32'h1..32'h8 back-to-back with out_ready = 1 -> out = 1..8 on consecutive cycles, in_ready constantly 1.
REQ-033 Hold out_ready = 0 and offer 32'hA then 32'hB -> count 2, in_ready 0, out = 32'hA stable; offer 32'hC held -> not accepted; release out_ready -> out sequence A, B, C with no loss.
REQ-034 In FULL (A in main, B in skid), assert flush with in = 32'hD, in_valid = 1 -> next cycle out = FLUSH_VALUE, out_valid 0, count 0, in_ready 1; A, B, D never appear.
REQ-035 Assert reset and flush together in FULL -> out = RESET_VALUE, not FLUSH_VALUE.
REQ-036 Random in_valid/out_ready over 10000 cycles, WIDTH = 8 -> scoreboard shows in-order, lossless delivery; REQ-021 holds every stall cycle.
